// File: rtl/elevator_ctrl.sv
// elevator_ctrl: SCAN (collective) elevator scheduler.
//
// Button presses are synchronised, edge-detected and latched as pending
// calls. A single FSM serves them in SCAN order: it keeps travelling in the
// current direction while calls remain ahead, then reverses. Floor travel
// and door dwell are timed by internal cycle counters.
//
// Ports:
//   clk          system clock, rising edge
//   nrst         asynchronous active-low reset
//   req          raw asynchronous floor-call buttons, active-high level
//   floor        current floor index (binary)
//   moving_up    motor up command   (state == MOVE_UP)
//   moving_down  motor down command (state == MOVE_DOWN)
//   door_open    door open command  (state == DOOR_OPEN)
//   pending      latched outstanding calls, one bit per floor
//   dbg_state    raw FSM state for observation (0 idle, 1 up, 2 down, 3 door)

module elevator_ctrl #(
  parameter int NUM_FLOORS  = 4,
  parameter int FLOOR_TICKS = 12000000,
  parameter int DOOR_TICKS  = 36000000,
  localparam int FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FW-1:0]         floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR_OPEN = 2'd3
  } state_t;

  // One timer width covers both travel and door dwell counts.
  localparam int TMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] FLOOR_LAST = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_TICKS - 1);

  // Input path registers
  logic [NUM_FLOORS-1:0] r_sync1;
  logic [NUM_FLOORS-1:0] r_sync2;
  logic [NUM_FLOORS-1:0] r_prev;

  // Scheduler state
  state_t                r_state;
  logic [FW-1:0]         r_floor;
  logic                  r_dir_up;
  logic [TW-1:0]         r_travel_cnt;
  logic [TW-1:0]         r_door_cnt;
  logic [NUM_FLOORS-1:0] r_pending;

  // Combinational helpers
  logic [NUM_FLOORS-1:0] w_edge;
  logic [NUM_FLOORS-1:0] w_here_mask;
  logic [NUM_FLOORS-1:0] w_up_mask;
  logic [NUM_FLOORS-1:0] w_dn_mask;
  logic [NUM_FLOORS-1:0] w_set;
  logic [NUM_FLOORS-1:0] w_clr;
  logic                  w_above;
  logic                  w_below;
  logic                  w_above_next;
  logic                  w_below_next;
  logic                  w_pend_here;
  logic                  w_pend_up;
  logic                  w_pend_dn;
  logic                  w_in_door;
  logic                  w_door_hit;
  logic                  w_travel_done;
  logic                  w_door_done;

  // ---------------------------------------------------------------------
  // Input path: two-flop synchroniser plus a previous-value flop, so a held
  // button yields exactly one rising-edge pulse.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= req;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_prev;

  // ---------------------------------------------------------------------
  // Floor-relative decodes. Loops compare indices as integers so no vector
  // is ever indexed outside its range at the top or bottom floor.
  // "next" variants look from the floor the car is about to arrive at.
  // ---------------------------------------------------------------------
  always_comb begin
    w_above      = 1'b0;
    w_below      = 1'b0;
    w_above_next = 1'b0;
    w_below_next = 1'b0;
    w_pend_here  = 1'b0;
    w_pend_up    = 1'b0;
    w_pend_dn    = 1'b0;
    w_here_mask  = '0;
    w_up_mask    = '0;
    w_dn_mask    = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(r_floor))     w_above      = w_above      | r_pending[i];
      if (i < int'(r_floor))     w_below      = w_below      | r_pending[i];
      if (i > int'(r_floor) + 1) w_above_next = w_above_next | r_pending[i];
      if (i < int'(r_floor) - 1) w_below_next = w_below_next | r_pending[i];
      if (i == int'(r_floor)) begin
        w_pend_here    = r_pending[i];
        w_here_mask[i] = 1'b1;
      end
      if (i == int'(r_floor) + 1) begin
        w_pend_up    = r_pending[i];
        w_up_mask[i] = 1'b1;
      end
      if (i == int'(r_floor) - 1) begin
        w_pend_dn    = r_pending[i];
        w_dn_mask[i] = 1'b1;
      end
    end
  end

  assign w_in_door     = (r_state == S_DOOR_OPEN);
  assign w_travel_done = (r_travel_cnt == FLOOR_LAST);
  assign w_door_done   = (r_door_cnt == DOOR_LAST);

  // A press at the floor whose door is already open extends the dwell
  // instead of registering a new call.
  assign w_door_hit = w_in_door & (|(w_edge & w_here_mask));
  assign w_set      = w_edge & ~(w_in_door ? w_here_mask : '0);

  // Clear the call of the floor being served on the cycle the FSM moves
  // into DOOR_OPEN there.
  always_comb begin
    w_clr = '0;
    case (r_state)
      S_IDLE:      if (w_pend_here)                 w_clr = w_here_mask;
      S_MOVE_UP:   if (w_travel_done && w_pend_up)  w_clr = w_up_mask;
      S_MOVE_DOWN: if (w_travel_done && w_pend_dn)  w_clr = w_dn_mask;
      default:     w_clr = '0;
    endcase
  end

  // Clear wins over a simultaneous set.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending | w_set) & ~w_clr;
    end
  end

  // ---------------------------------------------------------------------
  // Scheduler FSM. Each timer is held at 0 outside its own state.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= S_IDLE;
      r_floor      <= '0;
      r_dir_up     <= 1'b1;
      r_travel_cnt <= '0;
      r_door_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_travel_cnt <= '0;
          r_door_cnt   <= '0;
          if (w_pend_here) begin
            r_state <= S_DOOR_OPEN;
          end else if (w_above && (r_dir_up || !w_below)) begin
            r_state  <= S_MOVE_UP;
            r_dir_up <= 1'b1;
          end else if (w_below) begin
            r_state  <= S_MOVE_DOWN;
            r_dir_up <= 1'b0;
          end
        end

        S_MOVE_UP: begin
          r_door_cnt <= '0;
          if (w_travel_done) begin
            r_travel_cnt <= '0;
            r_floor      <= r_floor + 1'b1;
            if (w_pend_up)         r_state <= S_DOOR_OPEN;
            else if (w_above_next) r_state <= S_MOVE_UP;
            else                   r_state <= S_IDLE;
          end else begin
            r_travel_cnt <= r_travel_cnt + 1'b1;
          end
        end

        S_MOVE_DOWN: begin
          r_door_cnt <= '0;
          if (w_travel_done) begin
            r_travel_cnt <= '0;
            r_floor      <= r_floor - 1'b1;
            if (w_pend_dn)         r_state <= S_DOOR_OPEN;
            else if (w_below_next) r_state <= S_MOVE_DOWN;
            else                   r_state <= S_IDLE;
          end else begin
            r_travel_cnt <= r_travel_cnt + 1'b1;
          end
        end

        S_DOOR_OPEN: begin
          r_travel_cnt <= '0;
          if (w_door_hit) begin
            r_door_cnt <= '0;
          end else if (w_door_done) begin
            r_door_cnt <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_door_cnt <= r_door_cnt + 1'b1;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_travel_cnt <= '0;
          r_door_cnt   <= '0;
        end
      endcase
    end
  end

  assign floor       = r_floor;
  assign moving_up   = (r_state == S_MOVE_UP);
  assign moving_down = (r_state == S_MOVE_DOWN);
  assign door_open   = (r_state == S_DOOR_OPEN);
  assign pending     = r_pending;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed bench for elevator_ctrl with short timers
// (FLOOR_TICKS=4, DOOR_TICKS=6). Inputs are driven 1 time unit after each
// rising edge and outputs are sampled at the same point.

module tb_elevator_ctrl;

  logic       clk;
  logic       nrst;
  logic [3:0] req;
  logic [1:0] floor;
  logic       moving_up;
  logic       moving_down;
  logic       door_open;
  logic [3:0] pending;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int cnt_up   = 0;
  int cnt_dn   = 0;
  int cnt_door = 0;

  elevator_ctrl #(
    .NUM_FLOORS (4),
    .FLOOR_TICKS(4),
    .DOOR_TICKS (6)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .req        (req),
    .floor      (floor),
    .moving_up  (moving_up),
    .moving_down(moving_down),
    .door_open  (door_open),
    .pending    (pending),
    .dbg_state  (dbg_state)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cnt_up   += int'(moving_up);
      cnt_dn   += int'(moving_down);
      cnt_door += int'(door_open);
    end
  endtask

  task automatic clr_cnt();
    cnt_up   = 0;
    cnt_dn   = 0;
    cnt_door = 0;
  endtask

  // Checkers
  task automatic chk_st(input string tag, input logic [1:0] f, input logic u,
                        input logic d, input logic o, input logic [3:0] p);
    logic [8:0] got;
    logic [8:0] exp;
    got = {floor, moving_up, moving_down, door_open, pending};
    exp = {f, u, d, o, p};
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got floor=%0d up=%b dn=%b door=%b pend=%b, expected floor=%0d up=%b dn=%b door=%b pend=%b",
             tag, floor, moving_up, moving_down, door_open, pending, f, u, d, o, p);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    nrst = 1'b1;
    req  = 4'b0000;

    // 1: reset asserted mid-run, outputs clear asynchronously, stay idle
    tick();
    tick();
    nrst = 1'b0;
    #1;
    chk_st("rst_async", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    tick();
    chk_st("rst_held", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    nrst = 1'b1;
    clr_cnt();
    run(10);
    chk_st("rst_idle", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk_int("rst_no_motion", cnt_up + cnt_dn + cnt_door, 0);

    // 2: call at the current floor, pending for one cycle, 6-cycle dwell
    req = 4'b0001;
    run(3);
    chk_st("s2_pend", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0001);
    req = 4'b0000;
    clr_cnt();
    run(1);
    chk_st("s2_door", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
    run(11);
    chk_int("s2_door_cycles", cnt_door, 6);
    chk_st("s2_idle", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // 3: floor 0 -> floor 2
    req = 4'b0100;
    run(3);
    chk_st("s3_pend", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0100);
    req = 4'b0000;
    clr_cnt();
    run(1);
    chk_st("s3_start", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0100);
    run(4);
    chk_st("s3_floor1", 2'd1, 1'b1, 1'b0, 1'b0, 4'b0100);
    run(4);
    chk_st("s3_arrive", 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000);
    run(6);
    chk_st("s3_idle", 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk_int("s3_up_cycles", cnt_up, 8);
    chk_int("s3_dn_cycles", cnt_dn, 0);
    chk_int("s3_door_cycles", cnt_door, 6);

    // 4: SCAN order 2, 3, then 0
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    req  = 4'b1000;
    run(3);
    chk_st("s4_pend3", 2'd0, 1'b0, 1'b0, 1'b0, 4'b1000);
    req = 4'b0000;
    run(1);
    chk_st("s4_start", 2'd0, 1'b1, 1'b0, 1'b0, 4'b1000);
    run(4);
    chk_st("s4_floor1", 2'd1, 1'b1, 1'b0, 1'b0, 4'b1000);
    req = 4'b0101;
    clr_cnt();
    run(3);
    chk_st("s4_pend_all", 2'd1, 1'b1, 1'b0, 1'b0, 4'b1101);
    req = 4'b0000;
    run(1);
    chk_st("s4_serve2", 2'd2, 1'b0, 1'b0, 1'b1, 4'b1001);
    run(6);
    chk_st("s4_idle2", 2'd2, 1'b0, 1'b0, 1'b0, 4'b1001);
    run(1);
    chk_st("s4_resume_up", 2'd2, 1'b1, 1'b0, 1'b0, 4'b1001);
    run(4);
    chk_st("s4_serve3", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0001);
    run(6);
    chk_st("s4_idle3", 2'd3, 1'b0, 1'b0, 1'b0, 4'b0001);
    chk_int("s4_no_down_before", cnt_dn, 0);
    clr_cnt();
    run(1);
    chk_st("s4_reverse", 2'd3, 1'b0, 1'b1, 1'b0, 4'b0001);
    run(4);
    chk_st("s4_pass2", 2'd2, 1'b0, 1'b1, 1'b0, 4'b0001);
    run(8);
    chk_st("s4_serve0", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
    chk_int("s4_dn_cycles", cnt_dn, 12);
    run(6);
    chk_st("s4_final", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // 5: press at the open-door floor restarts the dwell
    req = 4'b0100;
    run(3);
    req = 4'b0000;
    run(9);
    chk_st("s5_door", 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000);
    run(2);
    req = 4'b0100;
    clr_cnt();
    run(2);
    chk_st("s5_t4", 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000);
    run(1);
    chk_st("s5_restart", 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000);
    run(3);
    req = 4'b0000;
    run(2);
    chk_st("s5_still_open", 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000);
    run(1);
    chk_st("s5_closed", 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk_int("s5_door_cycles", cnt_door, 8);
    run(5);
    chk_st("s5_quiet", 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000);

    // 6: reset while moving up at floor 1
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    req  = 4'b1000;
    run(3);
    req = 4'b0000;
    run(5);
    chk_st("s6_moving", 2'd1, 1'b1, 1'b0, 1'b0, 4'b1000);
    nrst = 1'b0;
    #1;
    chk_st("s6_rst_async", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    tick();
    nrst = 1'b1;
    clr_cnt();
    run(20);
    chk_st("s6_after", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk_int("s6_no_motion", cnt_up + cnt_dn + cnt_door, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
